// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared sizing helpers and default thresholds for sync_fifo_hs
//               and its storage sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  // Default depth and threshold settings.
  localparam int DEF_FIFO_DEPTH    = 16;
  localparam int DEF_AFULL_MARGIN  = 2;   // almost_full default = depth - margin
  localparam int DEF_AEMPTY_THRESH = 2;

  // Pointer width for a power-of-two depth; never narrower than 1 bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: one extra bit so that count == depth is representable.
  function automatic int count_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ram
// Description : Dual-port storage for sync_fifo_hs. One synchronous write port
//               and one read port. The read port is registered (with async
//               reset to 0) by default; when SYNC_FIFO_FWFT_EN is defined it
//               is a combinational look-up of mem[rd_addr].
// Ports       : clk      - clock, rising edge
//               rst      - async active-high reset (read register only)
//               wr_en    - write strobe
//               wr_addr  - write address
//               wr_data  - write data
//               rd_en    - read strobe (registered mode only)
//               rd_addr  - read address
//               rd_data  - read data
// Config      : SYNC_FIFO_FWFT_EN - combinational read port when defined
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [addr_width(FIFO_DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic                                rd_en,
  input  logic [addr_width(FIFO_DEPTH)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]               rd_data
);

  // Storage is deliberately not reset so it can map onto RAM primitives.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; the top gates it to 0 while empty.
  assign rd_data = mem[rd_addr];

  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, rst, rd_en};
`else
  // Registered read. When a write and a read hit the same slot on one edge
  // (full FIFO, write-through) the read returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule : sync_fifo_ram
`default_nettype wire

// File: rtl/sync_fifo_hs.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_hs
// Description : Single-clock FIFO with simultaneous read/write (including
//               write-through when full), programmable almost-full /
//               almost-empty thresholds and sticky overflow/underflow flags.
// Ports       : clk, rst        - clock and async active-high reset
//               wr_en, wr_data  - write request and data
//               rd_en, rd_data  - read request and data
//               full, empty     - count == FIFO_DEPTH / count == 0
//               almost_full     - count >= AFULL_THRESH
//               almost_empty    - count <= AEMPTY_THRESH
//               count           - entries held
//               overflow        - sticky, a write was rejected
//               underflow       - sticky, a read was rejected
//               err_clr         - synchronous clear of overflow/underflow
// Config      : SYNC_FIFO_FWFT_EN - first-word-fall-through read when defined
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_hs
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int AFULL_THRESH  = FIFO_DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 rd_en,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  output logic [count_width(FIFO_DEPTH)-1:0]   count,
  output logic                                 overflow,
  output logic                                 underflow,
  input  logic                                 err_clr
);

  localparam int AW = addr_width(FIFO_DEPTH);
  localparam int CW = count_width(FIFO_DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Status decodes of the registered count.
  assign empty        = (count == '0);
  assign full         = (count == CW'(FIFO_DEPTH));
  assign almost_full  = (count >= CW'(AFULL_THRESH));
  assign almost_empty = (count <= CW'(AEMPTY_THRESH));

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Acceptance rules already bound the count to 0..FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~err_clr) | (wr_en & ~wr_acc);
      underflow <= (underflow & ~err_clr) | (rd_en & ~rd_acc);
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; nothing meaningful to show while empty.
  assign rd_data = empty ? '0 : ram_rd_data;
`else
  assign rd_data = ram_rd_data;
`endif

endmodule : sync_fifo_hs
`default_nettype wire

// File: tb/tb_sync_fifo_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_hs
// Description : Directed self-checking bench for sync_fifo_hs (default
//               parameters: 8-bit data, depth 16, thresholds 14 / 2).
//               Read-data checks adapt to SYNC_FIFO_FWFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo_hs #(
    .DATA_WIDTH    (8),
    .FIFO_DEPTH    (16),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of traffic. Read data is checked where each mode presents it:
  // before the popping edge in FWFT, after it in registered mode.
  task automatic xfer(input bit do_wr, input logic [7:0] wd, input bit do_rd,
                      input bit chk, input logic [7:0] rexp, input string tag);
    wr_en   = do_wr;
    wr_data = wd;
    rd_en   = do_rd;
`ifdef SYNC_FIFO_FWFT_EN
    if (chk) check(tag, 32'(rd_data), 32'(rexp));
    step();
`else
    step();
    if (chk) check(tag, 32'(rd_data), 32'(rexp));
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);
    check("rst_rdata", 32'(rd_data), 0);
    step();
    rst = 1'b0;
    step();

    // Fill with 0x00..0x0F; almost_full from count 14, almost_empty up to 2
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, "");
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_afull", 32'(almost_full), (i + 1 >= 14) ? 1 : 0);
      check("fill_aempty", 32'(almost_empty), (i + 1 <= 2) ? 1 : 0);
    end
    check("fill_full", 32'(full), 1);

    // Write while full is rejected
    xfer(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, "");
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);

    // Error clear
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 0);

    // Write-through while full
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 8'(8'h10 + i), 1'b1, 1'b1, 8'(i), "wt_rdata");
      check("wt_count", 32'(count), 16);
      check("wt_full", 32'(full), 1);
    end
    check("wt_ovf", 32'(overflow), 0);

    // Drain: 0x04..0x0F then 0x10..0x13
    for (int i = 4; i < 16; i++)
      xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'(i), "drain_old");
    for (int i = 0; i < 4; i++)
      xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h10 + i), "drain_new");
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);
    check("drain_udf", 32'(underflow), 0);

    // Simultaneous write and read while empty
    xfer(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, "");
    check("ewr_count", 32'(count), 1);
    check("ewr_udf", 32'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("ewr_hold", 32'(rd_data), 32'h13);
`endif
    xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'h55, "ewr_rdata");
    check("ewr_empty", 32'(empty), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_udf", 32'(underflow), 0);

    // Wrap-around with interleaved write/read pairs
    for (int i = 0; i < 40; i++) begin
      xfer(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 8'h00, "");
      xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h80 + i), "wrap_rdata");
    end
    check("wrap_empty", 32'(empty), 1);
    check("wrap_udf", 32'(underflow), 0);

    // Reset mid-stream with 7 entries held
    for (int i = 0; i < 7; i++)
      xfer(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 8'h00, "");
    check("pre_rst_count", 32'(count), 7);
    #3;
    rst = 1'b1;
    #1;
    check("mrst_count", 32'(count), 0);
    check("mrst_empty", 32'(empty), 1);
    check("mrst_rdata", 32'(rd_data), 0);
    #1;
    rst = 1'b0;
    step();
    xfer(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "");
    check("post_rst_udf", 32'(underflow), 1);
    check("post_rst_count", 32'(count), 0);
    check("post_rst_rdata", 32'(rd_data), 0);
    xfer(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, "");
    check("post_rst_wcount", 32'(count), 1);
    xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'h77, "post_rst_head");
    check("post_rst_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sync_fifo_hs
`default_nettype wire
